// File: rtl/tlm_pkg.sv
// Shared encodings for the traffic light monitor: observed light codes,
// per-direction tracker states and the resync mapping from code to state.
package tlm_pkg;

    localparam logic [1:0] LIGHT_RED         = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW      = 2'b01;
    localparam logic [1:0] LIGHT_GREEN       = 2'b10;
    localparam logic [1:0] LIGHT_GREEN_BLINK = 2'b11;

    typedef enum logic [2:0] {
        ST_RED   = 3'd0,
        ST_PREP  = 3'd1,
        ST_GO    = 3'd2,
        ST_BLINK = 3'd3,
        ST_CLEAR = 3'd4
    } tlm_state_e;

    // A lone YELLOW is assumed to be the tail of a cycle, hence CLEAR.
    function automatic tlm_state_e resync_state(input logic [1:0] code);
        tlm_state_e st;
        case (code)
            LIGHT_RED:         st = ST_RED;
            LIGHT_YELLOW:      st = ST_CLEAR;
            LIGHT_GREEN:       st = ST_GO;
            LIGHT_GREEN_BLINK: st = ST_BLINK;
            default:           st = ST_RED;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/tlm_dir_tracker.sv
// One direction's light-sequence tracker: follows the legal cycle and reports
// out-of-sequence codes, resyncing to the state the code implies.
module tlm_dir_tracker
    import tlm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    input  logic       check_en,
    input  logic       seen,
    output tlm_state_e phase,
    output logic       illegal_det
);

    tlm_state_e state_r;
    tlm_state_e state_next_s;
    tlm_state_e legal_next_s;
    logic       bad_s;

    // Legal successor of the current state for the observed code
    always_comb begin
        legal_next_s = state_r;
        bad_s        = 1'b0;
        case (state_r)
            ST_RED: begin
                if (light == LIGHT_RED) legal_next_s = ST_RED;
                else if (light == LIGHT_YELLOW) legal_next_s = ST_PREP;
                else bad_s = 1'b1;
            end
            ST_PREP: begin
                if (light == LIGHT_YELLOW) legal_next_s = ST_PREP;
                else if (light == LIGHT_GREEN) legal_next_s = ST_GO;
                else bad_s = 1'b1;
            end
            ST_GO: begin
                if (light == LIGHT_GREEN) legal_next_s = ST_GO;
                else if (light == LIGHT_GREEN_BLINK) legal_next_s = ST_BLINK;
                else bad_s = 1'b1;
            end
            ST_BLINK: begin
                if (light == LIGHT_GREEN_BLINK) legal_next_s = ST_BLINK;
                else if (light == LIGHT_YELLOW) legal_next_s = ST_CLEAR;
                else bad_s = 1'b1;
            end
            ST_CLEAR: begin
                if (light == LIGHT_YELLOW) legal_next_s = ST_CLEAR;
                else if (light == LIGHT_RED) legal_next_s = ST_RED;
                else bad_s = 1'b1;
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Resync silently on the first sample or while checks are suspended
    always_comb begin
        if (seen && check_en && !bad_s) begin
            state_next_s = legal_next_s;
            illegal_det  = 1'b0;
        end else if (seen && check_en) begin
            state_next_s = resync_state(light);
            illegal_det  = 1'b1;
        end else begin
            state_next_s = resync_state(light);
            illegal_det  = 1'b0;
        end
    end

    // Tracker state register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_RED;
        else state_r <= state_next_s;
    end

    assign phase = state_r;

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: per-direction sequence checking, conflict detection,
// pattern duration and error counting. Define TLM_WATCHDOG_EN for the stuck watchdog.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       horizontal_light,
    input  logic [1:0]       vertical_light,
    input  logic             check_en,
    output logic [2:0]       h_phase,
    output logic [2:0]       v_phase,
    output logic             conflict,
    output logic             illegal,
    output logic             phase_done,
    output logic [CNT_W-1:0] last_dur,
    output logic [CNT_W-1:0] error_count,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    tlm_state_e        h_state_s, v_state_s;
    logic              h_ill_s, v_ill_s;
    logic              seen_r;
    logic [3:0]        pat_r, pat_s;
    logic [CNT_W-1:0]  hold_r, hold_inc_s;
    logic              conflict_r, conflict_s, conflict_rise_s;
    logic              illegal_r, phase_done_r, stuck_r;
    logic [CNT_W-1:0]  last_dur_r, error_count_r, err_next_s;
    logic              change_s, stuck_set_s, stuck_next_s;
    logic [2:0]        err_add_s;
    logic [CNT_W+2:0]  err_sum_s;

    tlm_dir_tracker u_h_tracker (
        .clk        (clk),
        .reset      (reset),
        .light      (horizontal_light),
        .check_en   (check_en),
        .seen       (seen_r),
        .phase      (h_state_s),
        .illegal_det(h_ill_s)
    );

    tlm_dir_tracker u_v_tracker (
        .clk        (clk),
        .reset      (reset),
        .light      (vertical_light),
        .check_en   (check_en),
        .seen       (seen_r),
        .phase      (v_state_s),
        .illegal_det(v_ill_s)
    );

    // Pattern change, conflict edge and saturating counter arithmetic
    always_comb begin
        pat_s           = {horizontal_light, vertical_light};
        change_s        = seen_r && (pat_s != pat_r);
        conflict_s      = (horizontal_light != LIGHT_RED) && (vertical_light != LIGHT_RED);
        conflict_rise_s = conflict_s && !conflict_r;
        if (hold_r == CNT_MAX) hold_inc_s = hold_r;
        else hold_inc_s = hold_r + CNT_W'(1'b1);
        err_add_s = {2'b00, h_ill_s} + {2'b00, v_ill_s} + {2'b00, conflict_rise_s}
                  + {2'b00, stuck_set_s};
        err_sum_s = {3'b000, error_count_r} + (CNT_W+3)'(err_add_s);
        if (err_sum_s > {3'b000, CNT_MAX}) err_next_s = CNT_MAX;
        else err_next_s = err_sum_s[CNT_W-1:0];
    end

`ifdef TLM_WATCHDOG_EN
    logic nonred_s;

    // Raise stuck once when a non-RED pattern is held for the full window
    always_comb begin
        nonred_s = (horizontal_light != LIGHT_RED) || (vertical_light != LIGHT_RED);
        if (seen_r && !change_s && nonred_s && !stuck_r &&
            (32'(hold_inc_s) == 32'(TIMEOUT_CYCLES - 1))) stuck_set_s = 1'b1;
        else stuck_set_s = 1'b0;
        if (change_s) stuck_next_s = 1'b0;
        else stuck_next_s = stuck_r | stuck_set_s;
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 32'sd0);
    assign stuck_set_s      = 1'b0;
    assign stuck_next_s     = 1'b0;
`endif

    // Output and bookkeeping registers; the first sample only seeds the pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_r        <= 1'b0;
            pat_r         <= 4'b0000;
            hold_r        <= '0;
            conflict_r    <= 1'b0;
            illegal_r     <= 1'b0;
            phase_done_r  <= 1'b0;
            last_dur_r    <= '0;
            error_count_r <= '0;
            stuck_r       <= 1'b0;
        end else begin
            seen_r        <= 1'b1;
            pat_r         <= pat_s;
            conflict_r    <= conflict_s;
            illegal_r     <= h_ill_s | v_ill_s;
            phase_done_r  <= change_s;
            error_count_r <= err_next_s;
            stuck_r       <= stuck_next_s;
            if (!seen_r) begin
                hold_r <= '0;
            end else if (change_s) begin
                last_dur_r <= hold_inc_s;
                hold_r     <= '0;
            end else begin
                hold_r <= hold_inc_s;
            end
        end
    end

    assign h_phase     = h_state_s;
    assign v_phase     = v_state_s;
    assign conflict    = conflict_r;
    assign illegal     = illegal_r;
    assign phase_done  = phase_done_r;
    assign last_dur    = last_dur_r;
    assign error_count = error_count_r;
    assign stuck       = stuck_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios with literal
// expectations plus random traffic checked against a behavioural model.
module tb_traffic_light_monitor;
    import tlm_pkg::*;

    localparam int CNT_W = 8;
    localparam int TO    = 20;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef TLM_WATCHDOG_EN
    localparam int WD_ON = 1;
`else
    localparam int WD_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       horizontal_light = 2'b00;
    logic [1:0]       vertical_light = 2'b00;
    logic             check_en = 1'b1;
    logic [2:0]       h_phase, v_phase;
    logic             conflict, illegal, phase_done, stuck;
    logic [CNT_W-1:0] last_dur, error_count;

    traffic_light_monitor #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .horizontal_light(horizontal_light), .vertical_light(vertical_light),
        .check_en(check_en),
        .h_phase(h_phase), .v_phase(v_phase), .conflict(conflict), .illegal(illegal),
        .phase_done(phase_done), .last_dur(last_dur), .error_count(error_count),
        .stuck(stuck)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int checks = 0;

    // Behavioural model: light sequence as a table of allowed (state, code) moves
    int legal_nx [5][4];
    int resync_tab [4] = '{0, 4, 2, 3};
    int m_st [2];
    int m_run, m_prev, m_last, m_err;
    bit m_seen, m_conf, m_ill, m_pd, m_stuck;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input int h, input int v, input bit ce, input bit rst);
        int ill, pat, n, codes[2];
        bit conf_now, pd, wd_set;
        if (rst) begin
            m_st[0] = 0; m_st[1] = 0; m_seen = 0; m_conf = 0; m_ill = 0; m_pd = 0;
            m_last = 0; m_err = 0; m_stuck = 0; m_run = 0; m_prev = 0;
        end else begin
            ill = 0;
            codes[0] = h; codes[1] = v;
            for (int d = 0; d < 2; d++) begin
                if (!m_seen || !ce) m_st[d] = resync_tab[codes[d]];
                else if (legal_nx[m_st[d]][codes[d]] >= 0) m_st[d] = legal_nx[m_st[d]][codes[d]];
                else begin
                    m_st[d] = resync_tab[codes[d]];
                    ill++;
                end
            end
            pat      = h * 4 + v;
            conf_now = (h != 0) && (v != 0);
            pd       = m_seen && (pat != m_prev);
            if (pd) m_last = imin(m_run, CMAX);
            n = (!m_seen || pd) ? 1 : m_run + 1;
            wd_set = (WD_ON != 0) && m_seen && !pd && ((h != 0) || (v != 0)) && !m_stuck
                     && (imin(n - 1, CMAX) == TO - 1);
            m_stuck = pd ? 1'b0 : (m_stuck | wd_set);
            m_err   = imin(m_err + ill + int'(conf_now && !m_conf) + int'(wd_set), CMAX);
            m_run   = n;
            m_ill   = (ill > 0);
            m_pd    = pd;
            m_conf  = conf_now;
            m_prev  = pat;
            m_seen  = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("h_phase", int'(h_phase), m_st[0]);
        chk("v_phase", int'(v_phase), m_st[1]);
        chk("conflict", int'(conflict), int'(m_conf));
        chk("illegal", int'(illegal), int'(m_ill));
        chk("phase_done", int'(phase_done), int'(m_pd));
        chk("last_dur", int'(last_dur), m_last);
        chk("error_count", int'(error_count), m_err);
        chk("stuck", int'(stuck), int'(m_stuck));
    endtask

    task automatic step(input logic [1:0] h, input logic [1:0] v, input logic ce, input logic rst);
        horizontal_light = h; vertical_light = v; check_en = ce; reset = rst;
        @(posedge clk);
        model_step(int'(h), int'(v), ce, rst);
        @(negedge clk);
        vectors++;
        compare_all();
    endtask

    task automatic hold(input logic [1:0] h, input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) step(h, v, 1'b1, 1'b0);
    endtask

    localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, B = 2'b11;

    initial begin
        #1_000_000;
        $display("FAIL bench_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] rh, rv;
        logic rce, rrst;
        int n;
        for (int s = 0; s < 5; s++) for (int c = 0; c < 4; c++) legal_nx[s][c] = -1;
        legal_nx[0][0] = 0; legal_nx[0][1] = 1; legal_nx[1][1] = 1; legal_nx[1][2] = 2;
        legal_nx[2][2] = 2; legal_nx[2][3] = 3; legal_nx[3][3] = 3; legal_nx[3][1] = 4;
        legal_nx[4][1] = 4; legal_nx[4][0] = 0;

        // Reset state
        step(R, R, 1'b1, 1'b1);
        step(R, R, 1'b1, 1'b1);
        chk("rst_err", int'(error_count), 0);
        chk("rst_last", int'(last_dur), 0);
        chk("rst_hphase", int'(h_phase), 0);
        hold(R, R, 3);
        chk("first_pd", int'(phase_done), 0);

        // Legal V cycle with H red: durations 2, 10, 4, 3
        step(R, Y, 1'b1, 1'b0); chk("seq_y_last", int'(last_dur), 3); hold(R, Y, 1);
        step(R, G, 1'b1, 1'b0); chk("seq_g_last", int'(last_dur), 2); hold(R, G, 9);
        step(R, B, 1'b1, 1'b0); chk("seq_b_pd", int'(phase_done), 1);
        chk("seq_b_last", int'(last_dur), 10); hold(R, B, 3);
        step(R, Y, 1'b1, 1'b0); chk("seq_c_last", int'(last_dur), 4); hold(R, Y, 2);
        step(R, R, 1'b1, 1'b0); chk("seq_r_last", int'(last_dur), 3);
        chk("seq_ill", int'(illegal), 0); chk("seq_err", int'(error_count), 0);
        step(R, R, 1'b1, 1'b0); chk("seq_pd_drop", int'(phase_done), 0);

        // Illegal RED -> GREEN jump
        step(R, G, 1'b1, 1'b0);
        chk("jump_ill", int'(illegal), 1); chk("jump_err", int'(error_count), 1);
        chk("jump_vphase", int'(v_phase), 2);
        step(R, G, 1'b1, 1'b0); chk("jump_ill_drop", int'(illegal), 0);
        step(R, B, 1'b1, 1'b0); step(R, Y, 1'b1, 1'b0); step(R, R, 1'b1, 1'b0);

        // Conflict for 5 cycles counts once
        step(Y, R, 1'b1, 1'b0); hold(G, R, 2);
        for (int i = 0; i < 5; i++) begin
            step(G, Y, 1'b1, 1'b0);
            chk("conf_level", int'(conflict), 1);
        end
        chk("conf_err", int'(error_count), 2);
        step(R, R, 1'b0, 1'b0);
        chk("conf_drop", int'(conflict), 0); chk("conf_err_hold", int'(error_count), 2);

        // Same jump with checks suspended
        step(R, G, 1'b0, 1'b0);
        chk("susp_ill", int'(illegal), 0); chk("susp_err", int'(error_count), 2);
        chk("susp_vphase", int'(v_phase), 2);
        step(R, R, 1'b0, 1'b0);

        // Watchdog: H green held 30 cycles
        step(Y, R, 1'b1, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            step(G, R, 1'b1, 1'b0);
            if (i == 19) chk("wd_pre", int'(stuck), 0);
            if (i == 20) chk("wd_set", int'(stuck), WD_ON);
            if (i == 30) chk("wd_sticky", int'(stuck), WD_ON);
        end
        step(B, R, 1'b1, 1'b0); chk("wd_clear", int'(stuck), 0);
        chk("wd_err", int'(error_count), 2 + WD_ON);
        step(Y, R, 1'b1, 1'b0); step(R, R, 1'b1, 1'b0);
        if (WD_ON == 0) begin
            step(R, B, 1'b1, 1'b0);
            step(R, R, 1'b0, 1'b0);
        end

        // Reset mid-BLINK while an illegal pulse would fire
        step(Y, R, 1'b1, 1'b0); step(G, R, 1'b1, 1'b0); hold(B, R, 2);
        chk("pre_rst_err", int'(error_count), 3);
        step(R, R, 1'b1, 1'b1);
        chk("rst_ill", int'(illegal), 0); chk("rst_pd", int'(phase_done), 0);
        chk("rst_err2", int'(error_count), 0); chk("rst_hph", int'(h_phase), 0);
        step(B, R, 1'b1, 1'b0);
        chk("post_ill", int'(illegal), 0); chk("post_pd", int'(phase_done), 0);
        chk("post_err", int'(error_count), 0); chk("post_hph", int'(h_phase), 3);

        // Duration saturation
        step(Y, R, 1'b1, 1'b0); hold(R, R, 300);
        step(R, Y, 1'b1, 1'b0); chk("sat_last", int'(last_dur), CMAX);
        step(R, G, 1'b1, 1'b0); step(R, B, 1'b1, 1'b0);
        step(R, Y, 1'b1, 1'b0); step(R, R, 1'b1, 1'b0);

        // Random traffic against the model
        rh = R; rv = R;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) >= 80) rh = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) >= 80) rv = 2'($urandom_range(0, 3));
            rce  = ($urandom_range(0, 9) != 0);
            rrst = ($urandom_range(0, 199) == 0);
            step(rh, rv, rce, rrst);
            if ($urandom_range(0, 99) == 0) begin
                n = $urandom_range(20, 300);
                for (int j = 0; j < n; j++) step(rh, rv, rce, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
